// File: rtl/upc_checkout_fsm.sv
// Checkout checker: latches a UPC code and mark bit on each scan edge, then flags the item
// as discounted or stolen, keeps saturating item/discount counts, and holds a clearable alarm.
module upc_checkout_fsm #(
  parameter int                  UPC_W         = 3,
  parameter logic [2**UPC_W-1:0] DISCOUNT_MASK = 8'b1100_1010,
  parameter logic [2**UPC_W-1:0] PRICEY_MASK   = 8'b0011_0001,
  parameter int                  CNT_W         = 4,
  parameter int                  ALARM_HOLD    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scan,
  input  logic [UPC_W-1:0] upc,
  input  logic             mark,
  input  logic             clear,
  output logic [UPC_W-1:0] item_code,
  output logic             valid,
  output logic             discounted,
  output logic             stolen,
  output logic             alarm,
  output logic             busy,
  output logic [CNT_W-1:0] item_count,
  output logic [CNT_W-1:0] disc_count
);

  localparam int                HOLD_W    = (ALARM_HOLD > 1) ? $clog2(ALARM_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(ALARM_HOLD - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {IDLE, EVAL, ALARM} state_t;

  state_t            state, next_state;
  logic              scan_q;
  logic              scan_edge;
  logic [UPC_W-1:0]  code_q;
  logic              mark_q;
  logic              disc, stol;
  logic [HOLD_W-1:0] hold;

  assign scan_edge = scan & ~scan_q;
  assign disc      = DISCOUNT_MASK[code_q];
  assign stol      = PRICEY_MASK[code_q] & ~mark_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // clear has priority over a scan edge arriving in the same IDLE cycle
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!clear && scan_edge) next_state = EVAL;
      EVAL:    next_state = stol ? ALARM : IDLE;
      ALARM:   if (clear && hold == '0) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    alarm = 1'b0;
    busy  = 1'b0;
    case (state)
      EVAL:    busy = 1'b1;
      ALARM: begin
        alarm = 1'b1;
        busy  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_q     <= 1'b0;
      code_q     <= '0;
      mark_q     <= 1'b0;
      hold       <= '0;
      item_code  <= '0;
      valid      <= 1'b0;
      discounted <= 1'b0;
      stolen     <= 1'b0;
      item_count <= '0;
      disc_count <= '0;
    end else begin
      // history always tracks scan, so edges seen while busy are simply lost
      scan_q <= scan;
      valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (clear) begin
            item_count <= '0;
            disc_count <= '0;
          end else if (scan_edge) begin
            code_q <= upc;
            mark_q <= mark;
          end
        end
        EVAL: begin
          item_code  <= code_q;
          discounted <= disc;
          stolen     <= stol;
          valid      <= 1'b1;
          if (stol) begin
            hold <= HOLD_LOAD;
          end else begin
            if (item_count != CNT_MAX)         item_count <= item_count + 1'b1;
            if (disc && disc_count != CNT_MAX) disc_count <= disc_count + 1'b1;
          end
        end
        ALARM: begin
          if (hold != '0) begin
            hold <= hold - 1'b1;
          end else if (clear) begin
            item_count <= '0;
            disc_count <= '0;
            stolen     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_upc_checkout_fsm.sv
// Directed bench for upc_checkout_fsm: vector table for ordinary scans plus hand-written
// sequences for alarm hold/clear, clear-vs-scan priority, saturation and async reset.
module tb_upc_checkout_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scan = 1'b0;
  logic [2:0] upc = '0;
  logic       mark = 1'b0;
  logic       clear = 1'b0;
  logic [2:0] item_code;
  logic       valid, discounted, stolen, alarm, busy;
  logic [3:0] item_count, disc_count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0] upc;
    logic       mark;
    logic       disc;
    logic       stol;
    logic [3:0] items;
    logic [3:0] discs;
  } vec_t;

  vec_t vecs[7];

  upc_checkout_fsm dut (
    .clk(clk), .reset(reset), .scan(scan), .upc(upc), .mark(mark), .clear(clear),
    .item_code(item_code), .valid(valid), .discounted(discounted), .stolen(stolen),
    .alarm(alarm), .busy(busy), .item_count(item_count), .disc_count(disc_count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_item_code"}, item_code, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_disc"}, discounted, 0);
    chk({tag, "_stolen"}, stolen, 0);
    chk({tag, "_alarm"}, alarm, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_items"}, item_count, 0);
    chk({tag, "_discs"}, disc_count, 0);
  endtask

  // raise scan at a negedge; valid must appear exactly after the second following posedge
  task automatic do_scan(input string tag, input logic [2:0] u, input logic m,
                         input logic ed, input logic es, input logic [3:0] ei,
                         input logic [3:0] edc);
    @(negedge clk);
    upc = u; mark = m; scan = 1'b1;
    @(negedge clk);
    scan = 1'b0;
    chk({tag, "_busy_eval"}, busy, 1);
    chk({tag, "_no_early_valid"}, valid, 0);
    @(negedge clk);
    chk({tag, "_valid"}, valid, 1);
    chk({tag, "_item_code"}, item_code, u);
    chk({tag, "_disc"}, discounted, ed);
    chk({tag, "_stolen"}, stolen, es);
    chk({tag, "_alarm"}, alarm, es);
    chk({tag, "_items"}, item_count, ei);
    chk({tag, "_discs"}, disc_count, edc);
  endtask

  initial begin
    vecs[0] = '{upc: 3'd3, mark: 1'b0, disc: 1'b1, stol: 1'b0, items: 4'd1, discs: 4'd1};
    vecs[1] = '{upc: 3'd4, mark: 1'b1, disc: 1'b0, stol: 1'b0, items: 4'd2, discs: 4'd1};
    vecs[2] = '{upc: 3'd1, mark: 1'b1, disc: 1'b1, stol: 1'b0, items: 4'd3, discs: 4'd2};
    vecs[3] = '{upc: 3'd6, mark: 1'b0, disc: 1'b1, stol: 1'b0, items: 4'd4, discs: 4'd3};
    vecs[4] = '{upc: 3'd5, mark: 1'b1, disc: 1'b0, stol: 1'b0, items: 4'd5, discs: 4'd3};
    vecs[5] = '{upc: 3'd7, mark: 1'b0, disc: 1'b1, stol: 1'b0, items: 4'd6, discs: 4'd4};
    vecs[6] = '{upc: 3'd0, mark: 1'b1, disc: 1'b0, stol: 1'b0, items: 4'd7, discs: 4'd4};

    // reset state
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;

    for (int i = 0; i < 7; i++)
      do_scan($sformatf("vec%0d", i), vecs[i].upc, vecs[i].mark, vecs[i].disc,
              vecs[i].stol, vecs[i].items, vecs[i].discs);

    // stolen item, scan edges during ALARM dropped, clear held through the hold window
    do_scan("steal0", 3'd0, 1'b0, 1'b0, 1'b1, 4'd7, 4'd4);
    clear = 1'b1; scan = 1'b1; upc = 3'd3; mark = 1'b1;
    @(negedge clk);
    chk("hold1_alarm", alarm, 1); chk("hold1_valid", valid, 0); scan = 1'b0;
    @(negedge clk);
    chk("hold2_alarm", alarm, 1); scan = 1'b1;
    @(negedge clk);
    chk("hold3_alarm", alarm, 1); chk("hold3_busy", busy, 1); scan = 1'b0;
    @(negedge clk);
    chk("clr_alarm", alarm, 0); chk("clr_busy", busy, 0); chk("clr_stolen", stolen, 0);
    chk("clr_items", item_count, 0); chk("clr_discs", disc_count, 0); chk("clr_valid", valid, 0);
    clear = 1'b0;
    @(negedge clk);
    chk("post_clr_valid", valid, 0); chk("post_clr_busy", busy, 0);

    // clear wins over a simultaneous scan edge in IDLE
    do_scan("pre_tie", 3'd3, 1'b0, 1'b1, 1'b0, 4'd1, 4'd1);
    @(negedge clk);
    chk("valid_pulse_len", valid, 0);
    scan = 1'b1; clear = 1'b1; upc = 3'd4; mark = 1'b1;
    @(negedge clk);
    chk("tie_busy", busy, 0); chk("tie_items", item_count, 0); chk("tie_discs", disc_count, 0);
    scan = 1'b0; clear = 1'b0;
    @(negedge clk);
    chk("tie_valid", valid, 0); chk("tie_busy2", busy, 0);
    chk("tie_code_held", item_code, 3); chk("tie_disc_held", discounted, 1);

    // saturation of item_count, then of disc increments with items pinned
    for (int i = 0; i < 17; i++)
      do_scan($sformatf("sat_item%0d", i), 3'd2, 1'b0, 1'b0, 1'b0,
              (i + 1 > 15) ? 4'd15 : 4'(i + 1), 4'd0);
    for (int i = 0; i < 3; i++)
      do_scan($sformatf("sat_disc%0d", i), 3'd1, 1'b1, 1'b1, 1'b0, 4'd15, 4'(i + 1));

    // reset in the middle of EVAL commits nothing
    @(negedge clk);
    upc = 3'd6; mark = 1'b0; scan = 1'b1;
    @(negedge clk);
    scan = 1'b0;
    #2 reset = 1'b1;
    #1 chk_zero("rst_eval");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_eval_items", item_count, 0); chk("rst_eval_valid", valid, 0);

    // short clear pulse early in ALARM must not release it; then async reset out of ALARM
    do_scan("steal5", 3'd5, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (6) @(negedge clk);
    chk("short_clr_alarm", alarm, 1); chk("short_clr_stolen", stolen, 1);
    #2 reset = 1'b1;
    #1 chk_zero("rst_alarm");
    @(negedge clk);
    reset = 1'b0;
    do_scan("after_rst", 3'd1, 1'b0, 1'b1, 1'b0, 4'd1, 4'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
